// File: rtl/jesd204b_pkg.sv
// ---------------------------------------------------------------------------
// jesd204b_pkg
// Shared constants for the JESD204B transmit link controller:
//   - control-character codes (K28.x) used during CGS and ILAS
//   - link state encodings (CGS / ILAS / DATA)
//   - ILAS length in multiframes and the SYNC~ low-run length
//   - ilas_octet(): builds one ILAS octet plus its K flag
// ---------------------------------------------------------------------------
package jesd204b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;   // /K/ comma, CGS filler
    localparam logic [7:0] K28_0 = 8'h1C;   // /R/ multiframe start
    localparam logic [7:0] K28_3 = 8'h7C;   // /A/ multiframe end
    localparam logic [7:0] K28_4 = 8'h9C;   // /Q/ config start marker

    localparam logic [1:0] ST_CGS  = 2'd0;
    localparam logic [1:0] ST_ILAS = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam int ILAS_MF_COUNT = 4;
    localparam int SYNC_LO_LEN   = 4;
    localparam int CFG_OCTETS    = 14;

    // Returns {k_flag, octet} for octet index idx of ILAS multiframe mf.
    // last_idx is F*K-1. Config octet n sits at cfg[111-8n -: 8].
    function automatic logic [8:0] ilas_octet(
        input logic [1:0]   mf,
        input logic [15:0]  idx,
        input logic [15:0]  last_idx,
        input logic [111:0] cfg
    );
        logic [8:0]   res;
        logic [111:0] cfg_sh;
        res    = {1'b0, idx[7:0]};
        cfg_sh = 112'd0;
        if (idx == 16'd0) begin
            res = {1'b1, K28_0};
        end else if (idx == last_idx) begin
            res = {1'b1, K28_3};
        end else if ((mf == 2'd1) && (idx == 16'd1)) begin
            res = {1'b1, K28_4};
        end else if ((mf == 2'd1) && (idx >= 16'd2) && (idx <= 16'(CFG_OCTETS + 1))) begin
            // shift the wanted config octet up into the top byte
            cfg_sh = cfg << {idx - 16'd2, 3'b000};
            res    = {1'b0, cfg_sh[111:104]};
        end else begin
            res = {1'b0, idx[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/jesd204b_sync_filter.sv
// ---------------------------------------------------------------------------
// jesd204b_sync_filter
// Brings the asynchronous SYNC~ into the clk domain and qualifies a resync
// request: a request is only honoured once the synchronized level has been
// low for SYNC_LO_LEN consecutive cycles, so short glitches are ignored.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   sync_n      : raw SYNC~ from the receiver (asynchronous)
//   sync_s      : synchronized SYNC~ (2-flop)
//   sync_lo     : synchronized SYNC~ low for SYNC_LO_LEN cycles, this one included
// ---------------------------------------------------------------------------
module jesd204b_sync_filter
    import jesd204b_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sync_n,
    output logic sync_s,
    output logic sync_lo
);

    // counter saturates one short of the run length; the current low
    // cycle completes the run
    localparam logic [2:0] LO_THRESH = 3'(SYNC_LO_LEN - 1);

    logic       meta_r;
    logic       sync_r;
    logic [2:0] low_cnt_r;

    // Two-flop synchronizer; both stages reset low (no link yet).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= sync_n;
            sync_r <= meta_r;
        end
    end

    // Counts completed low cycles of the synchronized level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_cnt_r <= 3'd0;
        end else if (sync_r) begin
            low_cnt_r <= 3'd0;
        end else if (low_cnt_r < LO_THRESH) begin
            low_cnt_r <= low_cnt_r + 3'd1;
        end else begin
            low_cnt_r <= low_cnt_r;
        end
    end

    assign sync_s  = sync_r;
    assign sync_lo = (!sync_r) && (low_cnt_r >= LO_THRESH);

endmodule

// File: rtl/jesd204b_tx_link_ctrl.sv
// ---------------------------------------------------------------------------
// jesd204b_tx_link_ctrl
// Transmit link-establishment sequencer for one JESD204B lane. Owns the LMFC
// beat counter and steps CGS -> ILAS (4 multiframes) -> DATA, falling back
// to CGS on a qualified SYNC~ low.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   sync_n       : SYNC~ from receiver (asynchronous, low = resync)
//   in_config    : 14 ILAS config octets, octet 0 = [111:104]
//   data_in      : transport data, octet 0 = MSB byte
//   data_ready   : data_in captured at the edge ending this cycle
//   out          : lane word, octet 0 = MSB byte
//   out_charisk  : per-octet K flag, MSB <-> octet 0
//   lmfc         : out carries beat 0 of a multiframe
//   state        : 0 CGS, 1 ILAS, 2 DATA
//   ilas_mf      : current ILAS multiframe
// ---------------------------------------------------------------------------
module jesd204b_tx_link_ctrl
    import jesd204b_pkg::*;
#(
    parameter int LANE_DATA_WIDTH = 32,
    parameter int OCTET_PER_SENT  = 4,
    parameter int OCTETS_PER_FR   = 3,
    parameter int FRAMES_PER_MF   = 8
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sync_n,
    input  logic [111:0]               in_config,
    input  logic [LANE_DATA_WIDTH-1:0] data_in,
    output logic                       data_ready,
    output logic [LANE_DATA_WIDTH-1:0] out,
    output logic [OCTET_PER_SENT-1:0]  out_charisk,
    output logic                       lmfc,
    output logic [1:0]                 state,
    output logic [1:0]                 ilas_mf
);

    localparam int OCT_PER_MF = OCTETS_PER_FR * FRAMES_PER_MF;
    localparam int BEATS      = OCT_PER_MF / OCTET_PER_SENT;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [15:0]       LAST_OCT  = 16'(OCT_PER_MF - 1);
    localparam logic [1:0]        MF_LAST   = 2'(ILAS_MF_COUNT - 1);

    logic                       sync_s;
    logic                       sync_lo;

    logic [BEAT_W-1:0]          beat_r;
    logic [1:0]                 state_r;
    logic [1:0]                 mf_r;
    logic [LANE_DATA_WIDTH-1:0] out_r;
    logic [OCTET_PER_SENT-1:0]  charisk_r;
    logic                       lmfc_r;

    logic [BEAT_W-1:0]          beat_nxt_s;
    logic [1:0]                 state_nxt_s;
    logic [1:0]                 mf_nxt_s;
    logic [LANE_DATA_WIDTH-1:0] word_nxt_s;
    logic [OCTET_PER_SENT-1:0]  k_nxt_s;
    logic [15:0]                oct_base_s;
    logic [8:0]                 oct_s;

    jesd204b_sync_filter u_sync_filter (
        .clk     (clk),
        .reset   (reset),
        .sync_n  (sync_n),
        .sync_s  (sync_s),
        .sync_lo (sync_lo)
    );

    // Beat counter successor: free-running modulo BEATS in every state.
    always_comb begin
        if (beat_r == BEAT_LAST) begin
            beat_nxt_s = BEAT_ZERO;
        end else begin
            beat_nxt_s = beat_r + BEAT_ONE;
        end
    end

    // Link state machine: decides state/multiframe of the next lane word.
    always_comb begin
        state_nxt_s = state_r;
        mf_nxt_s    = mf_r;
        case (state_r)
            ST_CGS: begin
                // ILAS may only start on a multiframe boundary
                if ((beat_r == BEAT_LAST) && sync_s) begin
                    state_nxt_s = ST_ILAS;
                end else begin
                    state_nxt_s = ST_CGS;
                end
                mf_nxt_s = 2'd0;
            end
            ST_ILAS: begin
                // resync wins over the MF3 -> DATA step
                if (sync_lo) begin
                    state_nxt_s = ST_CGS;
                    mf_nxt_s    = 2'd0;
                end else if (beat_r == BEAT_LAST) begin
                    if (mf_r == MF_LAST) begin
                        state_nxt_s = ST_DATA;
                        mf_nxt_s    = mf_r;
                    end else begin
                        state_nxt_s = ST_ILAS;
                        mf_nxt_s    = mf_r + 2'd1;
                    end
                end else begin
                    state_nxt_s = ST_ILAS;
                    mf_nxt_s    = mf_r;
                end
            end
            ST_DATA: begin
                if (sync_lo) begin
                    state_nxt_s = ST_CGS;
                    mf_nxt_s    = 2'd0;
                end else begin
                    state_nxt_s = ST_DATA;
                    mf_nxt_s    = mf_r;
                end
            end
            default: begin
                state_nxt_s = ST_CGS;
                mf_nxt_s    = 2'd0;
            end
        endcase
    end

    // Next lane word and K flags for the state/beat chosen above.
    always_comb begin
        word_nxt_s = {LANE_DATA_WIDTH{1'b0}};
        k_nxt_s    = {OCTET_PER_SENT{1'b0}};
        oct_base_s = 16'(beat_nxt_s) * 16'(OCTET_PER_SENT);
        oct_s      = 9'd0;
        case (state_nxt_s)
            ST_ILAS: begin
                for (int i = 0; i < OCTET_PER_SENT; i++) begin
                    oct_s = ilas_octet(mf_nxt_s, oct_base_s + 16'(i), LAST_OCT, in_config);
                    word_nxt_s[LANE_DATA_WIDTH-1-8*i -: 8] = oct_s[7:0];
                    k_nxt_s[OCTET_PER_SENT-1-i]            = oct_s[8];
                end
            end
            ST_DATA: begin
                word_nxt_s = data_in;
                k_nxt_s    = {OCTET_PER_SENT{1'b0}};
            end
            ST_CGS: begin
                word_nxt_s = {OCTET_PER_SENT{K28_5}};
                k_nxt_s    = {OCTET_PER_SENT{1'b1}};
            end
            default: begin
                word_nxt_s = {OCTET_PER_SENT{K28_5}};
                k_nxt_s    = {OCTET_PER_SENT{1'b1}};
            end
        endcase
    end

    // Output registers; beat held at BEATS-1 so the first word after reset is beat 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_r    <= BEAT_LAST;
            state_r   <= ST_CGS;
            mf_r      <= 2'd0;
            out_r     <= {OCTET_PER_SENT{K28_5}};
            charisk_r <= {OCTET_PER_SENT{1'b1}};
            lmfc_r    <= 1'b0;
        end else begin
            beat_r    <= beat_nxt_s;
            state_r   <= state_nxt_s;
            mf_r      <= mf_nxt_s;
            out_r     <= word_nxt_s;
            charisk_r <= k_nxt_s;
            lmfc_r    <= (beat_nxt_s == BEAT_ZERO);
        end
    end

    // data_ready mirrors "next word is DATA" using registered terms only.
    assign data_ready = (!sync_lo) &&
                        ((state_r == ST_DATA) ||
                         ((state_r == ST_ILAS) && (mf_r == MF_LAST) && (beat_r == BEAT_LAST)));

    assign out         = out_r;
    assign out_charisk = charisk_r;
    assign lmfc        = lmfc_r;
    assign state       = state_r;
    assign ilas_mf     = mf_r;

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jesd204b_tx_link_ctrl
// Scoreboard bench: expected lane words are queued as stimulus is driven and
// popped mid-cycle (negedge) when the DUT presents its registered outputs.
// ---------------------------------------------------------------------------
module tb_jesd204b_tx_link_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         sync_n;
    logic [111:0] in_config;
    logic [31:0]  data_in;
    logic         data_ready;
    logic [31:0]  lane_out;
    logic [3:0]   out_charisk;
    logic         lmfc;
    logic [1:0]   st;
    logic [1:0]   ilas_mf;

    typedef struct {
        logic [31:0] w;
        logic [3:0]  k;
        logic [1:0]  st;
        logic [1:0]  mf;
        bit          chk_mf;
        logic        lm;
        logic        dr;
    } exp_t;

    exp_t q[$];

    int err_cnt   = 0;
    int chk_cnt   = 0;
    int push_beat = 0;
    int tick_no   = 0;

    // Hand-derived ILAS words: MF0 (also MF2/MF3) and MF1 with the test config.
    logic [31:0] mf0_w[6] = '{32'h1C010203, 32'h04050607, 32'h08090A0B,
                              32'h0C0D0E0F, 32'h10111213, 32'h1415167C};
    logic [3:0]  mf0_k[6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic [31:0] mf1_w[6] = '{32'h1C9C7777, 32'h77778888, 32'h88887777,
                              32'h77778888, 32'h10111213, 32'h1415167C};
    logic [3:0]  mf1_k[6] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

    jesd204b_tx_link_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .sync_n      (sync_n),
        .in_config   (in_config),
        .data_in     (data_in),
        .data_ready  (data_ready),
        .out         (lane_out),
        .out_charisk (out_charisk),
        .lmfc        (lmfc),
        .state       (st),
        .ilas_mf     (ilas_mf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [3:0] k, input logic [1:0] s,
                        input logic [1:0] mf, input bit chk_mf, input logic dr);
        exp_t e;
        e.w      = w;
        e.k      = k;
        e.st     = s;
        e.mf     = mf;
        e.chk_mf = chk_mf;
        e.lm     = (push_beat == 0);
        e.dr     = dr;
        push_beat = (push_beat + 1) % 6;
        q.push_back(e);
    endtask

    task automatic push_cgs();
        push(32'hBCBCBCBC, 4'hF, 2'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic push_ilas(input int n);
        for (int i = 0; i < n; i++) begin
            int m;
            int b;
            m = i / 6;
            b = i % 6;
            if (m == 1) push(mf1_w[b], mf1_k[b], 2'd1, 2'(m), 1'b1, 1'b0);
            else        push(mf0_w[b], mf0_k[b], 2'd1, 2'(m), 1'b1, (m == 3) && (b == 5));
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        tick_no++;
        chk($sformatf("t%0d.sb_nonempty", tick_no), {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("t%0d.out", tick_no), lane_out, e.w);
            chk($sformatf("t%0d.charisk", tick_no), 32'(out_charisk), 32'(e.k));
            chk($sformatf("t%0d.state", tick_no), 32'(st), 32'(e.st));
            chk($sformatf("t%0d.lmfc", tick_no), 32'(lmfc), 32'(e.lm));
            chk($sformatf("t%0d.data_ready", tick_no), 32'(data_ready), 32'(e.dr));
            if (e.chk_mf) chk($sformatf("t%0d.ilas_mf", tick_no), 32'(ilas_mf), 32'(e.mf));
        end
    endtask

    // Idle in CGS until the current cycle is beat 2, raise sync_n, then expect
    // CGS beats 3..5 followed by n ILAS words.
    task automatic enter_ilas(input int n);
        int guard;
        guard = 0;
        do begin
            push_cgs();
            tick();
            guard++;
        end while ((push_beat != 3) && (guard < 20));
        sync_n = 1'b1;
        repeat (3) push_cgs();
        push_ilas(n);
        repeat (3 + n) tick();
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, ".out"}, lane_out, 32'hBCBCBCBC);
        chk({pfx, ".charisk"}, 32'(out_charisk), 32'hF);
        chk({pfx, ".state"}, 32'(st), 32'd0);
        chk({pfx, ".ilas_mf"}, 32'(ilas_mf), 32'd0);
        chk({pfx, ".lmfc"}, 32'(lmfc), 32'd0);
        chk({pfx, ".data_ready"}, 32'(data_ready), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        reset     = 1'b1;
        sync_n    = 1'b0;
        data_in   = 32'hDEADBEEF;
        in_config = 112'h7777_7777_8888_8888_7777_7777_8888;

        // reset and CGS hold, lmfc every 6th cycle from the first one
        repeat (20) @(negedge clk);
        chk_reset_vals("rst");
        reset     = 1'b0;
        push_beat = 0;
        repeat (12) begin
            push_cgs();
            tick();
        end

        // CGS exit and the full ILAS, data_ready on MF3 beat 5
        enter_ilas(24);

        // data entry: ramp, one cycle latency
        d = 32'h11111111;
        for (int n = 0; n < 8; n++) begin
            data_in = d;
            push(d, 4'h0, 2'd2, 2'd0, 1'b0, 1'b1);
            tick();
            d = d + 32'h11111111;
        end

        // 3-cycle SYNC~ glitch must be ignored
        sync_n = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j == 3) sync_n = 1'b1;
            data_in = d;
            push(d, 4'h0, 2'd2, 2'd0, 1'b0, 1'b1);
            tick();
            d = d + 32'h11111111;
        end

        // 4-cycle low: DATA for 5 more words (last with data_ready low), then CGS
        sync_n = 1'b0;
        for (int j = 0; j < 5; j++) begin
            data_in = d;
            push(d, 4'h0, 2'd2, 2'd0, 1'b0, (j < 4));
            tick();
            d = d + 32'h11111111;
        end
        repeat (4) begin
            push_cgs();
            tick();
        end

        // reset during MF2 beat 3 takes effect within the cycle
        enter_ilas(15);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        sync_n = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        push_beat = 0;
        q.delete();
        enter_ilas(6);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
